cfg_frame_serializer: RTL and testbench
=======================================

Name: cfg_frame_serializer

Overview:
- Upstream feeder for the latched configuration shift register (static + dynamic chain).
- Accepts one full configuration frame in parallel from the controller side through a valid/ready handshake.
- Serializes the frame onto SEL/MOSI with a per-bit shift strobe, then issues a latch strobe so the downstream register transfers shifted data to its latches.
- Optionally samples the returning SDO stream and checks it against the previously written frame.

Parameters:
- SIZESRSTAT, 88, static shift register length in bits
- SIZESRDYN, 16, dynamic shift register length in bits
- FRAME_LEN, SIZESRSTAT+SIZESRDYN (104), bits per frame
- CLKDIV, 4, CLK cycles per serial bit; legal range is 2 or more
- LSB_FIRST, 0, 0 shifts LOAD_DATA[FRAME_LEN-1] first; 1 shifts LOAD_DATA[0] first

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous reset, active-high
- LOAD_VALID  input  1  frame offered
- LOAD_READY  output  1  block can accept a frame
- LOAD_DATA  input  FRAME_LEN  frame contents, sampled on handshake
- ABORT  input  1  synchronous abort request
- SEL  output  1  frame window to downstream register
- MOSI  output  1  serial data bit
- SHIFT_EN  output  1  one-cycle strobe; downstream shifts MOSI in on this cycle
- LATCH_STB  output  1  one-cycle strobe; downstream latches shifted contents
- BUSY  output  1  high in any state except IDLE
- DONE  output  1  one-cycle pulse: frame completed and latched
- ABORTED  output  1  one-cycle pulse: frame dropped by ABORT
- SDO  input  1  serial data returned from downstream register
- RDBK_ERR  output  1  readback mismatch flag, valid with DONE

Behaviour:
- Reset (async, RST=1): state IDLE; all outputs 0 except LOAD_READY=1; frame, shadow, divider, and bit counters cleared.
- Handshake: acceptance occurs when LOAD_VALID && LOAD_READY at a CLK edge. LOAD_READY=1 only in IDLE. LOAD_DATA is captured into the frame register and the state goes to SETUP.
- SETUP: SEL=1, MOSI=first bit, no SHIFT_EN. Lasts CLKDIV cycles, then SHIFT.
- SHIFT:
  - Each bit occupies CLKDIV cycles with MOSI stable.
  - SHIFT_EN pulses on the last cycle of each bit period.
  - After each SHIFT_EN, MOSI advances to the next bit.
  - Bit counter runs 0..FRAME_LEN-1. After the SHIFT_EN for the final bit, the state goes to LATCH.
- LATCH: SEL=0, LATCH_STB=1 for exactly one cycle; the next state is DONE.
- DONE: DONE=1 for one cycle, RDBK_ERR valid in that same cycle; next state is IDLE.
  - The earliest next acceptance is the cycle after DONE.
- Total latency from the handshake edge to the DONE pulse is CLKDIV*(FRAME_LEN+1)+2 cycles.
  - With defaults: 4*105+2 = 422.
- ABORT:
  - In SETUP or SHIFT: the next state is IDLE, SEL drops immediately, and ABORTED pulses once. No LATCH_STB, no DONE. The shadow frame is not updated.
  - In IDLE, LATCH, or DONE: ignored.
  - ABORT together with LOAD_VALID in IDLE: the frame is accepted and ABORT is ignored.
- RST asserted mid-frame: immediate return to reset values. SEL falls asynchronously and no strobes are issued.
- The shadow frame (last completed frame) updates in the DONE state. It resets to all zeros, matching the downstream register reset contents.
- Counter widths are $clog2(CLKDIV) and $clog2(FRAME_LEN+1). No wrap occurs inside a frame.

Optional Feature:
- Macro: CFG_READBACK_CHECK_EN.
- With the macro defined:
  - SDO is sampled on every SHIFT_EN cycle into a FRAME_LEN capture register, using the same bit order as transmission.
  - In DONE, RDBK_ERR=1 if the capture register differs from the shadow frame (the previous frame, or all zeros after reset).
  - RDBK_ERR is 0 outside DONE.
- Without the macro: RDBK_ERR is tied to 0, SDO is unused, and no capture logic is built.

Test Plan:
- Reset then load 0xA5 repeated pattern (104 bits): 104 SHIFT_EN pulses 4 cycles apart, MOSI equals the pattern MSB first, one LATCH_STB, DONE exactly 422 cycles after the handshake, LOAD_READY low throughout.
- LSB_FIRST=1, CLKDIV=2, frame value 1: the first MOSI bit at SHIFT_EN is 1 and the remaining 103 bits are 0; DONE 212 cycles after the handshake.
- ABORT asserted at bit 50: SEL low on the next cycle, ABORTED single pulse, no LATCH_STB/DONE, LOAD_READY=1 the cycle after.
- RST asserted at bit 20: all outputs at reset values immediately. A new frame is then accepted and completes normally.
- Back-to-back frames with LOAD_VALID held high: the second handshake occurs the cycle after DONE; no SHIFT_EN overlaps.
- CFG_READBACK_CHECK_EN with a model 104-bit shift register looping SDO:
  - Frame X after reset gives RDBK_ERR=0 (zeros returned).
  - Frame Y with a correct model gives RDBK_ERR=0.
  - Corrupting one bit in the model gives RDBK_ERR=1.

Source files
------------

// File: rtl/cfg_frame_serializer.sv
// cfg_frame_serializer
//   Takes one configuration frame in parallel through a valid/ready handshake.
//   Shifts it out on SEL/MOSI with a per-bit SHIFT_EN strobe, then pulses
//   LATCH_STB so the downstream static+dynamic chain transfers data to its latches.
//   Optional macro CFG_READBACK_CHECK_EN: SDO is captured on every SHIFT_EN and
//   compared against the previously completed frame. The result is RDBK_ERR,
//   which is valid together with DONE.
//   Without the macro, RDBK_ERR is tied low and SDO is ignored.
module cfg_frame_serializer #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16,
  parameter int FRAME_LEN  = SIZESRSTAT + SIZESRDYN,
  parameter int CLKDIV     = 4,   // CLK cycles per serial bit, must be >= 2
  parameter int LSB_FIRST  = 0    // 0: LOAD_DATA[FRAME_LEN-1] goes first
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LOAD_VALID,
  output logic                 LOAD_READY,
  input  logic [FRAME_LEN-1:0] LOAD_DATA,
  input  logic                 ABORT,
  output logic                 SEL,
  output logic                 MOSI,
  output logic                 SHIFT_EN,
  output logic                 LATCH_STB,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ABORTED,
  input  logic                 SDO,
  output logic                 RDBK_ERR
);

  localparam int DW = $clog2(CLKDIV);
  localparam int BW = $clog2(FRAME_LEN + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_LATCH,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          div_q, div_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [FRAME_LEN-1:0]   frame_q, frame_d;
  logic                   abort_take;

  logic ready_q, ready_d;
  logic sel_q, sel_d;
  logic mosi_q, mosi_d;
  logic shift_q, shift_d;
  logic latch_q, latch_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic aborted_q, aborted_d;

  // Map the transmit sequence number of a bit to its position in the frame.
  function automatic logic [BW-1:0] bit_pos(input logic [BW-1:0] b);
    if (LSB_FIRST != 0) return b;
    return BIT_LAST - b;
  endfunction

  // Next-state logic: frame sequencing, divider, and bit counter.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    abort_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // LOAD_READY is high exactly in IDLE, so VALID alone completes the handshake.
        // An ABORT arriving in the same cycle has no effect here.
        if (LOAD_VALID) begin
          frame_d = LOAD_DATA;
          div_d   = '0;
          bit_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (ABORT) begin
          abort_take = 1'b1;
          div_d      = '0;
          bit_d      = '0;
          state_d    = ST_IDLE;
        end else if (div_q == DIV_LAST) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ABORT) begin
          abort_take = 1'b1;
          div_d      = '0;
          bit_d      = '0;
          state_d    = ST_IDLE;
        end else if (div_q == DIV_LAST) begin
          // This cycle carries SHIFT_EN; MOSI moves to the next bit afterwards.
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_LATCH;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_LATCH: state_d = ST_IDLE == ST_IDLE ? ST_DONE : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, so every output comes straight from a flop.
  always_comb begin
    ready_d   = (state_d == ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
    sel_d     = (state_d == ST_SETUP) || (state_d == ST_SHIFT);
    shift_d   = (state_d == ST_SHIFT) && (div_d == DIV_LAST);
    latch_d   = (state_d == ST_LATCH);
    done_d    = (state_d == ST_DONE);
    aborted_d = abort_take;
    mosi_d    = 1'b0;
    if (sel_d) begin
      mosi_d = frame_d[bit_pos(bit_d)];
    end
  end

  // State, counter, frame, and registered output flops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      ready_q   <= 1'b1;
      sel_q     <= 1'b0;
      mosi_q    <= 1'b0;
      shift_q   <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      ready_q   <= ready_d;
      sel_q     <= sel_d;
      mosi_q    <= mosi_d;
      shift_q   <= shift_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign LOAD_READY = ready_q;
  assign SEL        = sel_q;
  assign MOSI       = mosi_q;
  assign SHIFT_EN   = shift_q;
  assign LATCH_STB  = latch_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ABORTED    = aborted_q;

`ifdef CFG_READBACK_CHECK_EN
  // The downstream chain returns the frame it held before this one.
  // The shadow copy therefore holds the last fully completed frame.
  // It starts at zero, matching the downstream reset contents.
  logic [FRAME_LEN-1:0] shadow_q;
  logic [FRAME_LEN-1:0] capture_q;
  logic                 rdbk_q;

  // Capture SDO in transmit order, keep the shadow copy, and register the compare in DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow_q  <= '0;
      capture_q <= '0;
      rdbk_q    <= 1'b0;
    end else begin
      if (shift_q) begin
        capture_q[bit_pos(bit_q)] <= SDO;
      end
      if (state_q == ST_DONE) begin
        shadow_q <= frame_q;
      end
      rdbk_q <= (state_d == ST_DONE) && (capture_q != shadow_q);
    end
  end

  assign RDBK_ERR = rdbk_q;
`else
  logic unused_sdo;
  assign unused_sdo = SDO;
  assign RDBK_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_frame_serializer.sv
// Bench for cfg_frame_serializer.
// It uses two instances: the defaults (MSB first, CLKDIV=4) and an LSB-first, CLKDIV=2 variant.
// Each downstream chain is a 104-bit shift register that loops SDO back.
// The expected serial stream, timing, and readback result are computed from the frame value.
module tb_cfg_frame_serializer;
  localparam int N = 104;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic         a_valid, a_ready, a_abort, a_sel, a_mosi, a_shift, a_latch, a_busy, a_done, a_aborted, a_sdo, a_rdbk;
  logic [N-1:0] a_data;
  logic         b_valid, b_ready, b_abort, b_sel, b_mosi, b_shift, b_latch, b_busy, b_done, b_aborted, b_sdo, b_rdbk;
  logic [N-1:0] b_data;

  logic [N-1:0] sr_a, sr_b;
  logic         corrupt;
  logic [N-1:0] shadow_m [2];
  bit           use_b;
  logic         last_rdbk;

  always #5 clk = ~clk;

  cfg_frame_serializer u_a (
    .CLK(clk), .RST(rst), .LOAD_VALID(a_valid), .LOAD_READY(a_ready), .LOAD_DATA(a_data),
    .ABORT(a_abort), .SEL(a_sel), .MOSI(a_mosi), .SHIFT_EN(a_shift), .LATCH_STB(a_latch),
    .BUSY(a_busy), .DONE(a_done), .ABORTED(a_aborted), .SDO(a_sdo), .RDBK_ERR(a_rdbk)
  );

  cfg_frame_serializer #(.CLKDIV(2), .LSB_FIRST(1)) u_b (
    .CLK(clk), .RST(rst), .LOAD_VALID(b_valid), .LOAD_READY(b_ready), .LOAD_DATA(b_data),
    .ABORT(b_abort), .SEL(b_sel), .MOSI(b_mosi), .SHIFT_EN(b_shift), .LATCH_STB(b_latch),
    .BUSY(b_busy), .DONE(b_done), .ABORTED(b_aborted), .SDO(b_sdo), .RDBK_ERR(b_rdbk)
  );

  // Downstream chain models: shift MOSI in on SHIFT_EN, return the oldest bit on SDO.
  always @(posedge clk or posedge rst) begin
    if (rst) sr_a <= '0;
    else if (a_shift) sr_a <= {sr_a[N-2:0], a_mosi};
    else if (corrupt) sr_a[7] <= ~sr_a[7];
  end
  always @(posedge clk or posedge rst) begin
    if (rst) sr_b <= '0;
    else if (b_shift) sr_b <= {sr_b[N-2:0], b_mosi};
  end
  assign a_sdo = sr_a[N-1];
  assign b_sdo = sr_b[N-1];

  // Monitored view of whichever instance is under test.
  logic m_ready, m_sel, m_mosi, m_shift, m_latch, m_busy, m_done, m_aborted, m_rdbk, m_sdo;
  assign m_ready   = use_b ? b_ready   : a_ready;
  assign m_sel     = use_b ? b_sel     : a_sel;
  assign m_mosi    = use_b ? b_mosi    : a_mosi;
  assign m_shift   = use_b ? b_shift   : a_shift;
  assign m_latch   = use_b ? b_latch   : a_latch;
  assign m_busy    = use_b ? b_busy    : a_busy;
  assign m_done    = use_b ? b_done    : a_done;
  assign m_aborted = use_b ? b_aborted : a_aborted;
  assign m_rdbk    = use_b ? b_rdbk    : a_rdbk;
  assign m_sdo     = use_b ? b_sdo     : a_sdo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [N-1:0] d, input logic ab);
    if (use_b) begin b_valid = v; b_data = d; b_abort = ab; end
    else begin a_valid = v; a_data = d; a_abort = ab; end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_a"}, {23'd0, a_ready, a_sel, a_mosi, a_shift, a_latch, a_busy, a_done, a_aborted, a_rdbk}, 32'h100);
    check({tag, "_b"}, {23'd0, b_ready, b_sel, b_mosi, b_shift, b_latch, b_busy, b_done, b_aborted, b_rdbk}, 32'h100);
  endtask

  function automatic logic [N-1:0] rand_frame();
    logic [N-1:0] f;
    for (int k = 0; k < N; k++) f[k] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  // Call at a negedge. The handshake happens in this cycle.
  // With stop_at >= 0, the task returns in the cycle carrying that many SHIFT_ENs.
  task automatic run_frame(input logic [N-1:0] data, input int stop_at, input bit hold_after, input bit abort_hs);
    int C = use_b ? 2 : 4;
    int idx = use_b ? 1 : 0;
    int t, nsh, first_t, last_t, spacing_bad, mosi_bad, latch_n, latch_t, ready_hi, sel_bad, rd_stray, done_t, budget;
    logic [N-1:0] exp_bits, shadow_bits, sdo_cap;
    logic rd, exp_rd;
    for (int k = 0; k < N; k++) begin
      exp_bits[k]    = use_b ? data[k] : data[N-1-k];
      shadow_bits[k] = use_b ? shadow_m[idx][k] : shadow_m[idx][N-1-k];
    end
    nsh = 0; first_t = -1; last_t = 0; spacing_bad = 0; mosi_bad = 0; latch_n = 0; latch_t = -1;
    ready_hi = 0; sel_bad = 0; rd_stray = 0; done_t = -1; sdo_cap = '0; rd = 1'b0;
    budget = C * (N + 1) + 12;
    check("hs_ready", 32'(m_ready), 1);
    drive(1'b1, data, abort_hs);
    @(negedge clk);
    drive(1'b0, data, 1'b0);
    t = 1;
    check("setup_sel", 32'(m_sel), 1);
    check("setup_mosi", 32'(m_mosi), 32'(exp_bits[0]));
    check("setup_busy", 32'(m_busy), 1);
    if (abort_hs) check("abort_at_hs_ignored", 32'(m_aborted), 0);
    while (1) begin
      if (m_shift) begin
        if (nsh == 0) first_t = t;
        else if (t - last_t != C) spacing_bad++;
        if (nsh < N) begin
          if (m_mosi !== exp_bits[nsh]) mosi_bad++;
          sdo_cap[nsh] = m_sdo;
        end
        nsh++;
        last_t = t;
      end
      if (m_latch) begin
        latch_n++;
        latch_t = t;
        if (hold_after) drive(1'b1, data, 1'b0);
      end
      if (m_ready) ready_hi++;
      if (t <= C * (N + 1) && m_sel !== 1'b1) sel_bad++;
      if (m_rdbk && !m_done) rd_stray++;
      if (m_done) begin done_t = t; rd = m_rdbk; end
      if (stop_at >= 0 && nsh == stop_at) return;
      if (done_t >= 0 || t >= budget) break;
      @(negedge clk);
      t++;
    end
    check("done_latency", 32'(done_t), 32'(C * (N + 1) + 2));
    check("shift_count", 32'(nsh), N);
    check("first_shift", 32'(first_t), 32'(2 * C));
    check("shift_spacing_bad", 32'(spacing_bad), 0);
    check("mosi_bad", 32'(mosi_bad), 0);
    check("latch_count", 32'(latch_n), 1);
    check("latch_before_done", 32'(latch_t), 32'(done_t - 1));
    check("ready_high_busy", 32'(ready_hi), 0);
    check("sel_drop", 32'(sel_bad), 0);
    check("rdbk_outside_done", 32'(rd_stray), 0);
`ifdef CFG_READBACK_CHECK_EN
    exp_rd = (sdo_cap !== shadow_bits);
`else
    exp_rd = 1'b0;
`endif
    check("rdbk", 32'(rd), 32'(exp_rd));
    last_rdbk = rd;
    if (done_t >= 0) shadow_m[idx] = data;
    @(negedge clk);
    check("post_done_ready", 32'(m_ready), 1);
    check("done_one_cycle", 32'(m_done), 0);
  endtask

  initial begin
    logic [N-1:0] pat;
    int stray;
    rst = 1'b1; corrupt = 1'b0; use_b = 1'b0;
    a_valid = 0; a_abort = 0; a_data = '0;
    b_valid = 0; b_abort = 0; b_data = '0;
    shadow_m[0] = '0; shadow_m[1] = '0;
    last_rdbk = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset_hold");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outs("reset_release");

    // 0xA5 repeated, MSB first, CLKDIV=4.
    for (int k = 0; k < N / 8; k++) pat[k*8 +: 8] = 8'hA5;
    $display("frame A5 pattern on default instance");
    run_frame(pat, -1, 1'b0, 1'b0);
    check("rdbk_first_after_reset", 32'(last_rdbk), 0);

    // Value 1, LSB first, CLKDIV=2.
    use_b = 1'b1;
    $display("frame value 1 on LSB-first instance");
    run_frame(104'd1, -1, 1'b0, 1'b0);

    // Random frames; the last one has ABORT raised during the handshake.
    for (int r = 0; r < 3; r++) begin
      use_b = (r % 2) == 1;
      $display("random frame %0d on instance %0d", r, use_b);
      run_frame(rand_frame(), -1, 1'b0, r == 2);
    end
    use_b = 1'b0;

    // Abort while bit 50 is on the line.
    $display("abort at bit 50");
    run_frame(rand_frame(), 50, 1'b0, 1'b0);
    @(negedge clk);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    check("abort_sel", 32'(a_sel), 0);
    check("abort_pulse", 32'(a_aborted), 1);
    check("abort_ready", 32'(a_ready), 1);
    check("abort_busy", 32'(a_busy), 0);
    @(negedge clk);
    check("abort_pulse_once", 32'(a_aborted), 0);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      a_abort = (i >= 5 && i < 9);
      @(negedge clk);
      if (a_latch || a_done || a_shift || a_aborted || a_busy) stray++;
    end
    a_abort = 1'b0;
    check("abort_quiet_idle_abort_ignored", 32'(stray), 0);

    // Reset while bit 20 is on the line.
    $display("reset at bit 20");
    run_frame(rand_frame(), 20, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outs("reset_mid_frame");
    @(negedge clk);
    check_reset_outs("reset_mid_hold");
    rst = 1'b0;
    shadow_m[0] = '0; shadow_m[1] = '0;
    @(negedge clk);

    $display("frame X after mid-frame reset");
    run_frame(rand_frame(), -1, 1'b0, 1'b0);
    check("rdbk_x_zeros", 32'(last_rdbk), 0);

    $display("back-to-back frames Y1, Y2 with LOAD_VALID held");
    run_frame(rand_frame(), -1, 1'b1, 1'b0);
    run_frame(rand_frame(), -1, 1'b0, 1'b0);
    check("rdbk_y_clean", 32'(last_rdbk), 0);

    // Flip one bit held in the downstream model.
    corrupt = 1'b1;
    @(negedge clk);
    corrupt = 1'b0;
    $display("frame Z after corrupting one downstream bit");
    run_frame(rand_frame(), -1, 1'b0, 1'b0);
`ifdef CFG_READBACK_CHECK_EN
    check("rdbk_corrupt_flag", 32'(last_rdbk), 1);
`else
    check("rdbk_tied_low", 32'(last_rdbk), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
